mips_mainfsm: RTL
=================

# mips_mainfsm

Multicycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It sits directly upstream of the datapath's enable flip-flops (PC and instruction register). It drives their enables (`pcen`, `irwrite`) and every datapath mux/write strobe from the current opcode and the ALU `zero` flag. ALU function decode (`funct` → ALU control) is outside this block; this block supplies `aluop` only.

## Interface
Parameters: none; opcodes and state encodings come from the shared package.

- `clk`  in  1  rising-edge system clock
- `rst`  in  1  asynchronous, active-low reset
- `op`  in  6  instruction opcode, `instr[31:26]` from the instruction register
- `zero`  in  1  ALU zero flag, combinational from the datapath
- `pcen`  out  1  PC flop enable: `pcwrite | (branch & zero)`
- `irwrite`  out  1  instruction register enable
- `memwrite`  out  1  data memory write strobe
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `regwrite`  out  1  register file write enable
- `regdst`  out  1  write register select: 0 = rt, 1 = rd
- `memtoreg`  out  1  write-back select: 0 = ALUOut, 1 = Data
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `aluop`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `pcsrc`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target

## Operation
- State register: 4 bits, updated on `clk` rising edge. `rst` low forces `FETCH` asynchronously.
- All outputs are combinational from state only (Moore), except `pcen`, which also uses `zero`.
- Any output not listed for a state is 0.

State outputs:
- `FETCH`: irwrite=1, pcwrite=1, alusrcb=01
- `DECODE`: alusrcb=11
- `MEMADR`: alusrca=1, alusrcb=10
- `MEMRD`: iord=1
- `MEMWB`: regwrite=1, memtoreg=1
- `MEMWR`: iord=1, memwrite=1
- `EXECUTE`: alusrca=1, aluop=10
- `ALUWB`: regdst=1, regwrite=1
- `BRANCH`: alusrca=1, aluop=01, branch=1, pcsrc=01
- `ADDIEX`: alusrca=1, alusrcb=10
- `ADDIWB`: regwrite=1
- `JUMP`: pcwrite=1, pcsrc=10

Transitions:
- `FETCH` → `DECODE`
- `DECODE` branches on `op`:
  - lw 100011 or sw 101011 → `MEMADR`
  - R-type 000000 → `EXECUTE`
  - beq 000100 → `BRANCH`
  - addi 001000 → `ADDIEX`
  - j 000010 → `JUMP`
  - any other opcode → `FETCH`, with no write strobes issued
- `MEMADR` → `MEMRD` if op = lw, else `MEMWR`
- `MEMRD` → `MEMWB`
- `EXECUTE` → `ALUWB`
- `ADDIEX` → `ADDIWB`
- `MEMWB`, `MEMWR`, `ALUWB`, `BRANCH`, `ADDIWB`, `JUMP` → `FETCH`
- Unused state encodings → `FETCH` on the next edge; all outputs 0 while in them.

## Timing
- Values while `rst` is low are the `FETCH` outputs: irwrite=1, pcen=1, alusrcb=01, all others 0. Downstream flops share `rst` and hold their reset value, so these enables are harmless.
- The first edge after `rst` deasserts moves the FSM to `DECODE`. `FETCH` is therefore the first cycle after release.
- Cycles per instruction, counted from `FETCH`:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- `op` is sampled only in `DECODE` and `MEMADR`. The IR does not change outside `FETCH`, so `op` is stable there.
- `pcen` in `BRANCH` follows `zero` combinationally in the same cycle; the PC updates on that cycle's edge.
- `rst` asserted mid-instruction aborts it immediately, with no partial write. Outputs revert to `FETCH` values asynchronously.

## Structure
- Package `mips_pkg` holds:
  - `statetype_t` enum with the 12 states at 4-bit encoding, FETCH = 0
  - opcode localparams: `OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_ADDI`, `OP_J`
  - `aluop` encodings
- Single module with two processes: an `always_ff` state register and an `always_comb` next-state/output decode.
- No sub-module. The ALU decoder is a separate sibling block.

## Test plan
- Reset: `rst`=0 mid-`MEMRD` → state `FETCH`, irwrite=1, pcen=1, iord=0, regwrite=0 before the next edge.
- lw (op=100011) → sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB shows regwrite=1 and memtoreg=1; back in FETCH on cycle 6.
- sw (op=101011) → MEMWR cycle shows memwrite=1 and iord=1, with regwrite=0 throughout; 4 cycles total.
- beq (op=000100):
  - with zero=1 → BRANCH shows pcen=1 and pcsrc=01
  - with zero=0 → pcen=0
  - 3 cycles total in both cases.
- R-type then j (op=000000, then 000010) → ALUWB shows regdst=1 and regwrite=1; JUMP shows pcen=1 and pcsrc=10.
- Illegal op=111111 → DECODE returns to FETCH; no memwrite or regwrite is asserted in any cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// FSM state encoding, opcodes, ALU/mux select encodings, control bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } statetype_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_mainfsm.sv
// Multicycle MIPS main control FSM (Moore; pcen also uses zero).
// In: clk, rst (async active-low), op[5:0], zero. Out: datapath enables/selects.
module mips_mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc
);

  statetype_t state_q;
  statetype_t state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):    state_d = MEMADR;
          (op == OP_RTYPE): state_d = EXECUTE;
          (op == OP_BEQ):   state_d = BRANCH;
          (op == OP_ADDI):  state_d = ADDIEX;
          (op == OP_J):     state_d = JUMP;
          default:          state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB,
      MEMWR,
      ALUWB,
      BRANCH,
      ADDIWB,
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl = CTRL_NONE;
    unique case (state_q)
      FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PCSRC_ALUOUT;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PCSRC_JUMP;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

  // zero is live in BRANCH so the PC takes the target on the same edge.
  assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);
  assign irwrite  = ctrl.irwrite;
  assign memwrite = ctrl.memwrite;
  assign iord     = ctrl.iord;
  assign regwrite = ctrl.regwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;

endmodule
